test_ts_gen: RTL and testbench

//  Test-pattern transmitter for the 32-bit TS word interface (ts_dout/ts_dout_en) used on the mux IP path.

---
 rtl/test_ts_gen.sv | 132 +++++++++++++
 tb/tb_test_ts_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_ts_gen.sv
// Test-pattern transmitter for the 32-bit TS word interface: bursts of one descriptor
// word plus a 47-word MPEG-TS packet on a fixed PID, with optional CC error injection.
module test_ts_gen #(
  parameter logic [12:0] PID        = 13'h1386,
  parameter int          GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cc_err_inject,
  output logic [31:0] ts_dout,
  output logic        ts_dout_en,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // A zero gap would merge bursts, so the gap never drops below one cycle
  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GW      = (GAP_EFF < 2) ? 1 : $clog2(GAP_EFF);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_EFF - 1);
  localparam logic [5:0]    LAST_WIDX = 6'd47;

  logic [1:0]    state;
  logic [5:0]    widx;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    cc_prev;
  logic          cc_started;
  logic          inject_latch;

  logic          advance;
  logic          hdr_edge;
  logic [5:0]    widx_nxt;
  logic [3:0]    hdr_cc;
  logic [31:0]   word_nxt;

  function automatic logic [31:0] make_word(input logic [5:0]  idx,
                                            input logic [15:0] cnt,
                                            input logic [3:0]  cc);
    logic [31:0] w;
    if (idx == 6'd0)
      w = {16'hA55A, cnt};
    else if (idx == 6'd1)
      w = {8'h47, 3'b000, PID, 2'b00, 2'b01, cc};
    else
      w = {cnt, 8'h00, 2'b00, idx};
    return w;
  endfunction

  // widx is the index currently on ts_dout; the next word is built one step ahead
  always_comb begin
    advance  = (state == S_SEND) && (widx != LAST_WIDX);
    widx_nxt = advance ? (widx + 6'd1) : 6'd0;
    hdr_edge = advance && (widx == 6'd0);
    hdr_cc   = cc_started ? (cc_prev + (inject_latch ? 4'd2 : 4'd1)) : 4'd0;
    word_nxt = make_word(widx_nxt, pkt_cnt, hdr_cc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      widx         <= '0;
      gap_cnt      <= '0;
      cc_prev      <= '0;
      cc_started   <= 1'b0;
      inject_latch <= 1'b0;
      ts_dout      <= '0;
      ts_dout_en   <= 1'b0;
      busy         <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      // A pulse on the header edge survives the clear and targets the next packet
      inject_latch <= cc_err_inject | (inject_latch & ~hdr_edge);
      if (hdr_edge) begin
        cc_prev    <= hdr_cc;
        cc_started <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (enable) begin
            state      <= S_SEND;
            widx       <= 6'd0;
            ts_dout    <= word_nxt;
            ts_dout_en <= 1'b1;
            busy       <= 1'b1;
          end
        end

        S_SEND: begin
          if (widx == LAST_WIDX) begin
            state      <= S_GAP;
            gap_cnt    <= '0;
            ts_dout    <= '0;
            ts_dout_en <= 1'b0;
            pkt_cnt    <= pkt_cnt + 16'd1;
          end else begin
            widx    <= widx_nxt;
            ts_dout <= word_nxt;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (enable) begin
              state      <= S_SEND;
              widx       <= 6'd0;
              ts_dout    <= word_nxt;
              ts_dout_en <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          ts_dout    <= '0;
          ts_dout_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_ts_gen.sv
// Bench for test_ts_gen: vector table, directed corner sequences and random
// stimulus checked every cycle against a position-based stream model.
module tb_test_ts_gen;

  localparam int          GAP    = 4;
  localparam logic [12:0] TB_PID = 13'h1386;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        cc_err_inject = 1'b0;
  logic [31:0] ts_dout;
  logic        ts_dout_en;
  logic        busy;
  logic [15:0] pkt_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  test_ts_gen #(.PID(TB_PID), .GAP_CYCLES(GAP)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cc_err_inject (cc_err_inject),
    .ts_dout       (ts_dout),
    .ts_dout_en    (ts_dout_en),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int          cycles;
    logic        en;
    logic        inj;
    logic        exp_en;
    logic [31:0] exp_dout;
    logic        exp_busy;
    logic [15:0] exp_pkt;
  } vec_t;

  vec_t vecs[$];

  // Stream model: m_pos is the position inside a burst+gap frame, -1 when idle
  int          m_pos;
  logic [15:0] m_pkts;
  logic [3:0]  m_cc;
  bit          m_any;
  bit          m_pend;

  // Monitor state built purely from observed outputs
  int          burst_idx;
  bit          prev_en;
  int          gap_len;
  bit          gap_valid;
  int          en_cycles;
  int          hdrs[$];
  int          gaps[$];
  int          lens[$];
  logic [31:0] word0s[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos  = -1;
    m_pkts = '0;
    m_cc   = '0;
    m_any  = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic model_step(input logic en_in, input logic inj_in);
    if (m_pos < 0)                m_pos = en_in ? 0 : -1;
    else if (m_pos < 47)          m_pos++;
    else if (m_pos == 47) begin   m_pos = 48; m_pkts++; end
    else if (m_pos == 47 + GAP)   m_pos = en_in ? 0 : -1;
    else                          m_pos++;
    if (m_pos == 1) begin
      m_cc   = m_any ? (m_cc + (m_pend ? 4'd2 : 4'd1)) : 4'd0;
      m_any  = 1'b1;
      m_pend = inj_in;
    end else if (inj_in) begin
      m_pend = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    if (m_pos < 0 || m_pos > 47) w = 32'h0;
    else if (m_pos == 0)         w = {16'hA55A, m_pkts};
    else if (m_pos == 1)         w = {8'h47, 3'b000, TB_PID, 2'b00, 2'b01, m_cc};
    else                         w = {m_pkts, 8'h00, 8'(m_pos)};
    return w;
  endfunction

  task automatic mon_clear();
    burst_idx = -1;
    prev_en   = 1'b0;
    gap_len   = 0;
    gap_valid = 1'b0;
    en_cycles = 0;
    hdrs.delete();
    gaps.delete();
    lens.delete();
    word0s.delete();
  endtask

  task automatic observe();
    if (ts_dout_en) begin
      if (!prev_en) begin
        if (gap_valid) gaps.push_back(gap_len);
        burst_idx = 0;
        word0s.push_back(ts_dout);
      end else begin
        burst_idx++;
      end
      if (burst_idx == 1) hdrs.push_back(int'(ts_dout[3:0]));
      gap_len = 0;
      en_cycles++;
    end else begin
      if (prev_en) begin
        lens.push_back(burst_idx + 1);
        gap_valid = 1'b1;
      end
      gap_len++;
    end
    prev_en = ts_dout_en;
  endtask

  task automatic check_output();
    check("model_en",   32'(ts_dout_en), 32'(m_pos >= 0 && m_pos <= 47));
    check("model_dout", ts_dout,         model_word());
    check("model_busy", 32'(busy),       32'(m_pos >= 0));
    check("model_pkt",  32'(pkt_cnt),    32'(m_pkts));
  endtask

  task automatic apply_stimulus(input logic en_v, input logic inj_v);
    enable        = en_v;
    cc_err_inject = inj_v;
    @(posedge clk);
    model_step(en_v, inj_v);
    @(negedge clk);
    check_output();
    observe();
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_en",   32'(ts_dout_en), 32'h0);
      check("rst_dout", ts_dout,         32'h0);
      check("rst_busy", 32'(busy),       32'h0);
      check("rst_pkt",  32'(pkt_cnt),    32'h0);
      enable        = 1'($urandom_range(0, 1));
      cc_err_inject = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    enable        = 1'b0;
    cc_err_inject = 1'b0;
    rst           = 1'b1;
    mon_clear();
  endtask

  initial begin
    int budget;
    int breaks;
    bit en_r;

    vecs.push_back('{3,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 16'd0});
    vecs.push_back('{1,  1'b1, 1'b0, 1'b1, 32'hA55A0000, 1'b1, 16'd0});
    vecs.push_back('{1,  1'b0, 1'b0, 1'b1, 32'h47138610, 1'b1, 16'd0});
    vecs.push_back('{1,  1'b0, 1'b0, 1'b1, 32'h00000002, 1'b1, 16'd0});
    vecs.push_back('{45, 1'b0, 1'b0, 1'b1, 32'h0000002F, 1'b1, 16'd0});
    vecs.push_back('{1,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 16'd1});
    vecs.push_back('{3,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 16'd1});
    vecs.push_back('{1,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 16'd1});
    vecs.push_back('{5,  1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 16'd1});
    vecs.push_back('{1,  1'b1, 1'b0, 1'b1, 32'hA55A0001, 1'b1, 16'd1});
    vecs.push_back('{1,  1'b1, 1'b0, 1'b1, 32'h47138611, 1'b1, 16'd1});
    vecs.push_back('{46, 1'b1, 1'b0, 1'b1, 32'h0001002F, 1'b1, 16'd1});
    vecs.push_back('{4,  1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 16'd2});
    vecs.push_back('{1,  1'b1, 1'b0, 1'b1, 32'hA55A0002, 1'b1, 16'd2});
    vecs.push_back('{1,  1'b0, 1'b0, 1'b1, 32'h47138612, 1'b1, 16'd2});

    model_reset();
    mon_clear();
    apply_reset(5);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].cycles; c++)
        apply_stimulus(vecs[i].en, vecs[i].inj);
      check($sformatf("vec%0d_en", i),   32'(ts_dout_en), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d_dout", i), ts_dout,         vecs[i].exp_dout);
      check($sformatf("vec%0d_busy", i), 32'(busy),       32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_pkt", i),  32'(pkt_cnt),    32'(vecs[i].exp_pkt));
    end

    // 18 back-to-back packets: CC walks through a wrap, gaps stay fixed
    apply_reset(3);
    budget = 1200;
    while (hdrs.size() < 18 && budget > 0) begin
      apply_stimulus(1'b1, 1'b0);
      budget--;
    end
    check("t3_hdr_count", hdrs.size(), 32'd18);
    if (hdrs.size() >= 18)
      for (int i = 0; i < 18; i++)
        check($sformatf("t3_cc%0d", i), hdrs[i], i % 16);
    check("t3_gap_count", 32'(gaps.size() >= 17), 32'd1);
    for (int i = 0; i < gaps.size(); i++)
      check($sformatf("t3_gap%0d", i), gaps[i], GAP);
    check("t3_pkt_cnt", 32'(pkt_cnt), 32'd17);

    // Injected CC error during packet 3 shows up in packet 4 only
    apply_reset(3);
    budget = 200;
    while (hdrs.size() < 3 && budget > 0) begin
      apply_stimulus(1'b1, 1'b0);
      budget--;
    end
    apply_stimulus(1'b1, 1'b1);
    budget = 200;
    while (hdrs.size() < 5 && budget > 0) begin
      apply_stimulus(1'b1, 1'b0);
      budget--;
    end
    check("t4_hdr_count", hdrs.size(), 32'd5);
    if (hdrs.size() >= 5) begin
      check("t4_cc3", hdrs[2], 32'd2);
      check("t4_cc4", hdrs[3], 32'd4);
      check("t4_cc5", hdrs[4], 32'd5);
      breaks = 0;
      for (int i = 1; i < 5; i++)
        if (hdrs[i] != (hdrs[i-1] + 1) % 16) breaks++;
      check("t4_checker_flags", breaks, 32'd1);
    end

    // Dropping enable mid-burst never truncates the burst
    apply_reset(3);
    budget = 20;
    while (burst_idx != 10 && budget > 0) begin
      apply_stimulus(1'b1, 1'b0);
      budget--;
    end
    check("t5_reached_idx10", burst_idx, 32'd10);
    for (int i = 0; i < 60; i++) apply_stimulus(1'b0, 1'b0);
    check("t5_bursts", lens.size(), 32'd1);
    if (lens.size() >= 1) check("t5_len", lens[0], 32'd48);
    check("t5_en_cycles", en_cycles, 32'd48);
    check("t5_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a burst
    apply_reset(3);
    budget = 40;
    while (burst_idx != 20 && budget > 0) begin
      apply_stimulus(1'b1, 1'b0);
      budget--;
    end
    check("t6_reached_idx20", burst_idx, 32'd20);
    #1 rst = 1'b0;
    #1;
    check("t6_async_en",   32'(ts_dout_en), 32'd0);
    check("t6_async_dout", ts_dout,         32'd0);
    check("t6_async_busy", 32'(busy),       32'd0);
    apply_reset(3);
    budget = 10;
    while (hdrs.size() < 1 && budget > 0) begin
      apply_stimulus(1'b1, 1'b0);
      budget--;
    end
    check("t6_hdr_seen", hdrs.size(), 32'd1);
    if (word0s.size() >= 1) check("t6_word0", word0s[0], 32'hA55A0000);
    if (hdrs.size() >= 1)   check("t6_cc0", hdrs[0], 32'd0);

    // Random enable and inject traffic against the model
    apply_reset(2);
    en_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      apply_stimulus(en_r, 1'($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
